uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, default byte width and TX-path clocking constants.
package uart_pkg;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned BAUD        = 9600;
  localparam int unsigned BAUD_DIV    = CLK_HZ / BAUD;
  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot winner select, round-robin from ptr with wrap.
// Define UART_ARB_FIXED_PRIO_EN for lowest-index-wins priority (ptr ignored).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
)(
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan high to low so the lowest requesting index is written last.
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (((req >> i) & NUM_REQ'(1)) != '0) grant = NUM_REQ'(1) << i;
    end
  end
`else
  int unsigned idx;
  logic        found;

  // First requester found walking upward from ptr, modulo NUM_REQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && (((req >> idx) & NUM_REQ'(1)) != '0)) begin
        grant = NUM_REQ'(1) << idx;
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core among NUM_REQ byte requesters; start pulse, busy handshake, start timeout.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = UART_DATA_W,
  parameter int unsigned START_TMO = 4
)(
  input  logic                        CLK100MHZ,
  input  logic                        CPU_RESETN,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TMO_W = $clog2(START_TMO + 1);

  arb_state_t         state, next_state;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_id;
  logic [DATA_W-1:0]  win_data;
  logic [TMO_W-1:0]   tmo_cnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // One-hot grant to index, then select that requester's byte.
  always_comb begin
    win_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (((grant >> i) & NUM_REQ'(1)) != '0) win_id = IDX_W'(i);
    end
  end

  assign win_data = DATA_W'(req_data >> (32'(win_id) * DATA_W));

  // Next state and accept strobe; nothing is accepted while reset is held.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (CPU_RESETN && !tx_busy && (|req_valid)) begin
          req_ready  = grant;
          next_state = START;
        end
      end
      START:     next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)                                 next_state = WAIT_DONE;
        else if (tmo_cnt == TMO_W'(START_TMO - 1))   next_state = IDLE;
      end
      WAIT_DONE: if (!tx_busy) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state    <= next_state;
      tx_start <= (next_state == START);
      active   <= (next_state != IDLE);
      if (state == IDLE && next_state == START) begin
        tx_data  <= win_data;
        grant_id <= win_id;
      end
      if (state == START)                    tmo_cnt <= '0;
      else if (state == WAIT_BUSY && !tx_busy) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

`ifdef UART_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // Search resumes just past the last owner whenever the transmitter is released.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rr_ptr <= '0;
    end else if (state != IDLE && next_state == IDLE) begin
      rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle transaction model plus directed literal checks.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          active;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .START_TMO(TMO)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Transaction model: owner of the transmitter and how far its byte has progressed.
  bit            m_free;
  int            m_age, m_wait, m_ptr, m_gid;
  bit            m_seen;
  logic [DW-1:0] m_data;
  int            log_id[$];
  logic [DW-1:0] log_data[$];

  logic [N-1:0]  s_ready;
  logic          s_start, s_active;
  logic [DW-1:0] s_data;
  logic [1:0]    s_gid;

  bit            core_en, req_auto;
  int            core_mode, pend, flen;
  logic [N-1:0]  hold_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int s;
    s = ptr;
`ifdef UART_ARB_FIXED_PRIO_EN
    s = 0;
`endif
    for (int k = 0; k < N; k++) if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_free = 1'b1; m_age = 0; m_wait = 0; m_ptr = 0; m_gid = 0; m_seen = 1'b0; m_data = '0;
  endtask

  // One clock: check at negedge, advance model, then drive requesters and busy core after posedge.
  task automatic tick();
    logic [N-1:0] exp_ready;
    int w;
    @(negedge clk);
    if (!rst_n) model_reset();
    w = pick(req_valid, m_ptr);
    exp_ready = '0;
    if (rst_n && m_free && !tx_busy && w >= 0) exp_ready = 4'(1) << w;
    s_ready = req_ready; s_start = tx_start; s_active = active; s_data = tx_data; s_gid = grant_id;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("tx_start",  32'(tx_start),  32'(!m_free && m_age == 1));
    chk("active",    32'(active),    32'(!m_free));
    chk("grant_id",  32'(grant_id),  32'(m_gid));
    chk("tx_data",   32'(tx_data),   32'(m_data));
    if (rst_n) begin
      if (m_free) begin
        if (exp_ready != '0) begin
          m_free = 1'b0; m_age = 1; m_gid = w; m_data = req_data[w*DW +: DW];
          m_seen = 1'b0; m_wait = 0;
          log_id.push_back(w); log_data.push_back(m_data);
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (!m_seen) begin
        if (tx_busy) m_seen = 1'b1;
        else begin
          m_wait++;
          if (m_wait == TMO) begin m_free = 1'b1; m_ptr = (m_gid + 1) % N; end
        end
      end else if (!tx_busy) begin
        m_free = 1'b1; m_ptr = (m_gid + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_ready[i]) begin
        if (hold_mask[i]) req_data[i*DW +: DW] = DW'($urandom);
        else req_valid[i] = 1'b0;
      end else if (req_auto && req_valid[i] && $urandom_range(0, 31) == 0) begin
        req_valid[i] = 1'b0;
      end
      if (req_auto && !req_valid[i] && $urandom_range(0, 2) == 0) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
    if (core_en) begin
      if (s_start) begin
        if (core_mode == 2 || (core_mode == 0 && $urandom_range(0, 7) == 0)) pend = -1;
        else if (core_mode == 1) begin pend = 0; flen = 5; end
        else begin pend = $urandom_range(0, 2); flen = $urandom_range(1, 8); end
      end
      if (pend == 0) begin tx_busy = 1'b1; pend = -1; end
      else if (pend > 0) pend--;
      else if (tx_busy) begin
        if (flen == 0) tx_busy = 1'b0; else flen--;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin tick(); n++; end
    while ((s_active || tx_busy || req_valid != '0) && n < 600);
    chk({name, "_idle_reached"}, 32'(n < 600), 32'(1));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; pend = -1; tx_busy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n_rdy, n_act, n_st;
    int exp_fair[4];
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    core_en = 1'b0; core_mode = 1; req_auto = 1'b0; hold_mask = '0; pend = -1; flen = 0;
    model_reset();

    // Reset with requests pending: nothing accepted, all outputs zero.
    req_valid = 4'b1111; req_data = 32'hA5A5A5A5;
    repeat (3) tick();
    chk("rst_ready",  32'(s_ready),  32'(0));
    chk("rst_start",  32'(s_start),  32'(0));
    chk("rst_active", 32'(s_active), 32'(0));
    chk("rst_data",   32'(s_data),   32'(0));
    chk("rst_gid",    32'(s_gid),    32'(0));

    // Single request on requester 0.
    req_valid = '0; rst_n = 1'b1; core_en = 1'b1; core_mode = 1;
    tick();
    base = log_id.size();
    req_valid[0] = 1'b1; req_data[7:0] = 8'h41;
    tick();
    chk("single_ready", 32'(s_ready), 32'(4'b0001));
    tick();
    chk("single_start",     32'(s_start), 32'(1));
    chk("single_ready_off", 32'(s_ready), 32'(0));
    chk("single_gid",       32'(s_gid),   32'(0));
    chk("single_data",      32'(s_data),  32'(8'h41));
    wait_idle("single");
    chk("single_count", 32'(log_id.size() - base), 32'(1));

    // All four requesters from a fresh pointer.
    pulse_reset();
    base = log_id.size();
    req_valid = 4'b1111; req_data = 32'h44434241;
    wait_idle("all4");
    chk("all4_count", 32'(log_id.size() - base), 32'(4));
    for (int k = 0; k < 4; k++) chk("all4_seq", 32'(log_data[base + k]), 32'(8'h41 + k));

    // Fairness between two always-valid requesters.
    pulse_reset();
    base = log_id.size();
    hold_mask = 4'b0101; req_valid = 4'b0101; req_data = 32'h00330011;
    for (int k = 0; k < 600 && log_id.size() < base + 4; k++) tick();
    hold_mask = '0; req_valid = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_fair = '{0, 0, 0, 0};
`else
    exp_fair = '{0, 2, 0, 2};
`endif
    chk("fair_count", 32'(log_id.size() >= base + 4), 32'(1));
    for (int k = 0; k < 4; k++) chk("fair_seq", 32'(log_id[base + k]), 32'(exp_fair[k]));
    wait_idle("fair");

    // Core busy externally: no grant until it falls.
    core_en = 1'b0; tx_busy = 1'b1; req_valid = 4'b0010; req_data[15:8] = 8'h5A;
    n_rdy = 0;
    repeat (50) begin tick(); if (s_ready != '0) n_rdy++; end
    chk("ext_busy_no_ready", 32'(n_rdy), 32'(0));
    tx_busy = 1'b0;
    tick();
    chk("ext_busy_ready", 32'(s_ready), 32'(4'b0010));

    // Busy never rises: START then START_TMO waiting cycles, then release.
    n_act = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (s_active) n_act++; else break;
    end
    chk("tmo_active_cycles", 32'(n_act), 32'(5));
    chk("tmo_gid", 32'(s_gid), 32'(1));
    core_en = 1'b1; core_mode = 1;
    req_valid = 4'b0101; req_data = 32'h00770066;
    tick();
`ifdef UART_ARB_FIXED_PRIO_EN
    chk("tmo_next", 32'(s_ready), 32'(4'b0001));
`else
    chk("tmo_next", 32'(s_ready), 32'(4'b0100));
`endif
    wait_idle("tmo");

    // Reset during WAIT_DONE.
    req_valid = 4'b1000; req_data[31:24] = 8'h77;
    repeat (4) tick();
    chk("mid_pre_active", 32'(s_active), 32'(1));
    chk("mid_pre_busy",   32'(tx_busy),  32'(1));
    #2;
    rst_n = 1'b0; core_en = 1'b0; tx_busy = 1'b0; pend = -1; req_valid = 4'b0001;
    #1;
    chk("mid_rst_ready",  32'(req_ready), 32'(0));
    chk("mid_rst_start",  32'(tx_start),  32'(0));
    chk("mid_rst_active", 32'(active),    32'(0));
    chk("mid_rst_data",   32'(tx_data),   32'(0));
    chk("mid_rst_gid",    32'(grant_id),  32'(0));
    repeat (3) tick();
    req_valid = '0; rst_n = 1'b1;
    n_st = 0;
    repeat (20) begin tick(); if (s_start) n_st++; end
    chk("post_rst_no_start", 32'(n_st), 32'(0));
    core_en = 1'b1;
    base = log_id.size();
    req_valid = 4'b0100; req_data[23:16] = 8'h33;
    wait_idle("post_rst");
    chk("post_rst_id",   32'(log_id[base]),   32'(2));
    chk("post_rst_data", 32'(log_data[base]), 32'(8'h33));

    // Random traffic with a random busy core, including occasional dropped starts.
    pulse_reset();
    core_en = 1'b1; core_mode = 0; req_auto = 1'b1;
    base = log_id.size();
    repeat (3000) tick();
    req_auto = 1'b0; req_valid = '0;
    wait_idle("rand");
    chk("rand_progress", 32'(log_id.size() - base > 100), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
